// File: rtl/vlsu_cam_search_client_if.sv
// Request, CAM read-port and response bundle for vlsu_cam_search_client.
// Optional macro VLSU_CAM_SEARCH_STATS_EN adds per-port hit/miss counter outputs.
interface vlsu_cam_search_client_if #(
  parameter int unsigned WIDTH = 50,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned READ  = 3,
  parameter int unsigned TAG_W = 4
);
  localparam int unsigned ADDRESS = $clog2(DEPTH);

  logic [READ-1:0]         req_valid_i;
  logic [READ-1:0]         req_ready_o;
  logic [READ*WIDTH-1:0]   req_data_i;
  logic [READ*TAG_W-1:0]   req_tag_i;
  logic                    flush_i;
  logic [READ-1:0]         cam_read_o;
  logic [READ*WIDTH-1:0]   cam_read_data_o;
  logic [READ-1:0]         cam_match_i;
  logic [READ*ADDRESS-1:0] cam_match_addr_i;
  logic [READ-1:0]         rsp_valid_o;
  logic [READ-1:0]         rsp_ready_i;
  logic [READ-1:0]         rsp_hit_o;
  logic [READ*ADDRESS-1:0] rsp_addr_o;
  logic [READ*TAG_W-1:0]   rsp_tag_o;
`ifdef VLSU_CAM_SEARCH_STATS_EN
  logic [READ*16-1:0]      hit_cnt_o;
  logic [READ*16-1:0]      miss_cnt_o;
`endif

  // master is the search client, slave is its environment (requester, CAM, consumer)
  modport master (
`ifdef VLSU_CAM_SEARCH_STATS_EN
    output hit_cnt_o, miss_cnt_o,
`endif
    input  req_valid_i, req_data_i, req_tag_i, flush_i, cam_match_i, cam_match_addr_i, rsp_ready_i,
    output req_ready_o, cam_read_o, cam_read_data_o, rsp_valid_o, rsp_hit_o, rsp_addr_o, rsp_tag_o
  );

  modport slave (
`ifdef VLSU_CAM_SEARCH_STATS_EN
    input  hit_cnt_o, miss_cnt_o,
`endif
    output req_valid_i, req_data_i, req_tag_i, flush_i, cam_match_i, cam_match_addr_i, rsp_ready_i,
    input  req_ready_o, cam_read_o, cam_read_data_o, rsp_valid_o, rsp_hit_o, rsp_addr_o, rsp_tag_o
  );
endinterface

// File: rtl/vlsu_cam_search_client.sv
// Search-issuing side of the VLSU CAM: credit-gated requests, CAM latency tracking, per-port response FIFOs.
// Optional macro VLSU_CAM_SEARCH_STATS_EN adds saturating per-port hit/miss counters.
module vlsu_cam_search_client #(
  parameter int unsigned WIDTH      = 50,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned READ       = 3,
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned CAM_LAT    = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                      clk,
  input logic                      rst,
  vlsu_cam_search_client_if.master bus
);
  localparam int unsigned ADDRESS = $clog2(DEPTH);
  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned STAT_W  = 16;

  logic [READ-1:0]    fire;
  logic               ready_q   [READ];
  logic               rsp_vld_q [READ];
  logic               rsp_hit_q [READ];
  logic [ADDRESS-1:0] rsp_addr_q[READ];
  logic [TAG_W-1:0]   rsp_tag_q [READ];
`ifdef VLSU_CAM_SEARCH_STATS_EN
  logic [STAT_W-1:0]  hit_cnt_q [READ];
  logic [STAT_W-1:0]  miss_cnt_q[READ];
`endif

  // A search launches only with a credit in hand, never during flush or reset
  always_comb begin
    fire = '0;
    for (int p = 0; p < READ; p++) begin
      fire[p] = bus.req_valid_i[p] & ready_q[p] & ~bus.flush_i & ~rst;
    end
  end

  assign bus.cam_read_o      = fire;
  assign bus.cam_read_data_o = bus.req_data_i;

  always_comb begin
    bus.req_ready_o = '0;
    bus.rsp_valid_o = '0;
    bus.rsp_hit_o   = '0;
    bus.rsp_addr_o  = '0;
    bus.rsp_tag_o   = '0;
    for (int p = 0; p < READ; p++) begin
      bus.req_ready_o[p]                 = ready_q[p];
      bus.rsp_valid_o[p]                 = rsp_vld_q[p];
      bus.rsp_hit_o[p]                   = rsp_hit_q[p];
      bus.rsp_addr_o[p*ADDRESS +: ADDRESS] = rsp_addr_q[p];
      bus.rsp_tag_o[p*TAG_W +: TAG_W]    = rsp_tag_q[p];
    end
  end

`ifdef VLSU_CAM_SEARCH_STATS_EN
  always_comb begin
    bus.hit_cnt_o  = '0;
    bus.miss_cnt_o = '0;
    for (int p = 0; p < READ; p++) begin
      bus.hit_cnt_o[p*STAT_W +: STAT_W]  = hit_cnt_q[p];
      bus.miss_cnt_o[p*STAT_W +: STAT_W] = miss_cnt_q[p];
    end
  end
`endif

  for (genvar p = 0; p < READ; p++) begin : g_port
    logic               pipe_vld[CAM_LAT];
    logic [TAG_W-1:0]   pipe_tag[CAM_LAT];
    logic               mem_hit [FIFO_DEPTH];
    logic [ADDRESS-1:0] mem_addr[FIFO_DEPTH];
    logic [TAG_W-1:0]   mem_tag [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr, rd_next;
    logic [CNT_W-1:0]   count, cnt_mid, cnt_next;
    logic [CNT_W-1:0]   credit, credit_next;
    logic               push, pop, push_hit;
    logic [ADDRESS-1:0] push_addr;
    logic [TAG_W-1:0]   push_tag;

    always_comb begin
      pop         = rsp_vld_q[p] & bus.rsp_ready_i[p];
      push        = pipe_vld[CAM_LAT-1];
      push_hit    = bus.cam_match_i[p];
      push_addr   = push_hit ? bus.cam_match_addr_i[p*ADDRESS +: ADDRESS] : '0;
      push_tag    = pipe_tag[CAM_LAT-1];
      cnt_mid     = count - CNT_W'(pop);
      cnt_next    = cnt_mid + CNT_W'(push);
      rd_next     = rd_ptr + PTR_W'(pop);
      credit_next = credit - CNT_W'(fire[p]) + CNT_W'(pop);
    end

    // FIFO storage needs no reset; occupancy is tracked separately
    always_ff @(posedge clk) begin
      if (push && !bus.flush_i) begin
        mem_hit[wr_ptr]  <= push_hit;
        mem_addr[wr_ptr] <= push_addr;
        mem_tag[wr_ptr]  <= push_tag;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s < CAM_LAT; s++) begin
          pipe_vld[s] <= 1'b0;
          pipe_tag[s] <= '0;
        end
        wr_ptr        <= '0;
        rd_ptr        <= '0;
        count         <= '0;
        credit        <= CNT_W'(FIFO_DEPTH);
        ready_q[p]    <= 1'b1;
        rsp_vld_q[p]  <= 1'b0;
        rsp_hit_q[p]  <= 1'b0;
        rsp_addr_q[p] <= '0;
        rsp_tag_q[p]  <= '0;
      end else if (bus.flush_i) begin
        for (int s = 0; s < CAM_LAT; s++) begin
          pipe_vld[s] <= 1'b0;
        end
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        count        <= '0;
        credit       <= CNT_W'(FIFO_DEPTH);
        ready_q[p]   <= 1'b1;
        rsp_vld_q[p] <= 1'b0;
      end else begin
        pipe_vld[0] <= fire[p];
        pipe_tag[0] <= bus.req_tag_i[p*TAG_W +: TAG_W];
        for (int s = 1; s < CAM_LAT; s++) begin
          pipe_vld[s] <= pipe_vld[s-1];
          pipe_tag[s] <= pipe_tag[s-1];
        end
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        rd_ptr       <= rd_next;
        count        <= cnt_next;
        credit       <= credit_next;
        ready_q[p]   <= (credit_next != '0);
        rsp_vld_q[p] <= (cnt_next != '0);
        // Output registers preload the next head; they hold their value while empty
        if (cnt_next != '0) begin
          if (cnt_mid == '0) begin
            rsp_hit_q[p]  <= push_hit;
            rsp_addr_q[p] <= push_addr;
            rsp_tag_q[p]  <= push_tag;
          end else begin
            rsp_hit_q[p]  <= mem_hit[rd_next];
            rsp_addr_q[p] <= mem_addr[rd_next];
            rsp_tag_q[p]  <= mem_tag[rd_next];
          end
        end
      end
    end

`ifdef VLSU_CAM_SEARCH_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
      if (rst || bus.flush_i) begin
        hit_cnt_q[p]  <= '0;
        miss_cnt_q[p] <= '0;
      end else if (pop) begin
        if (rsp_hit_q[p] && hit_cnt_q[p] != '1) begin
          hit_cnt_q[p] <= hit_cnt_q[p] + STAT_W'(1);
        end
        if (!rsp_hit_q[p] && miss_cnt_q[p] != '1) begin
          miss_cnt_q[p] <= miss_cnt_q[p] + STAT_W'(1);
        end
      end
    end
`endif

    // Credits are taken at fire time, so a push into a full FIFO without a pop is a design bug
    a_no_overflow: assert property (@(posedge clk) disable iff (rst || bus.flush_i)
                                    !(push && !pop && count == CNT_W'(FIFO_DEPTH)))
      else $error("response FIFO overflow on port %0d", p);
  end
endmodule

// File: tb/tb_vlsu_cam_search_client.sv
// Scoreboard bench for vlsu_cam_search_client: CAM model, credit/latency reference model, random and directed stimulus.
module tb_vlsu_cam_search_client;
  localparam int unsigned WIDTH = 50;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned READ  = 3;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned AW    = 5;
  localparam int unsigned FD    = 4;

  typedef struct {
    logic             hit;
    logic [AW-1:0]    addr;
    logic [TAG_W-1:0] tag;
    int               rdy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   cred[READ];
  exp_t sbq[READ][$];

  vlsu_cam_search_client_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .READ(READ), .TAG_W(TAG_W)) bus ();

  vlsu_cam_search_client #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .READ(READ), .TAG_W(TAG_W), .CAM_LAT(1), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // CAM contents: j+1 for j<16, j-15 above; lowest matching address wins
  function automatic void cam_lookup(input logic [WIDTH-1:0] key, output logic hit, output logic [AW-1:0] addr);
    hit  = 1'b0;
    addr = '0;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      int e;
      e = (j < 16) ? j + 1 : j - 15;
      if (key == WIDTH'(e)) begin
        hit  = 1'b1;
        addr = AW'(j);
      end
    end
  endfunction

  // CAM with one cycle of latency; misses report a junk address of 9
  always @(posedge clk) begin
    for (int p = 0; p < READ; p++) begin
      logic h;
      logic [AW-1:0] a;
      cam_lookup(bus.cam_read_data_o[p*WIDTH +: WIDTH], h, a);
      if (bus.cam_read_o[p]) begin
        bus.cam_match_i[p]              <= h;
        bus.cam_match_addr_i[p*AW +: AW] <= h ? a : AW'(9);
      end else begin
        bus.cam_match_i[p]              <= 1'b0;
        bus.cam_match_addr_i[p*AW +: AW] <= AW'($urandom_range(0, 31));
      end
    end
  end

  // Issue side: credit model predicts ready/fire and queues the expected response
  always @(negedge clk) begin
    for (int p = 0; p < READ; p++) begin
      if (rst) begin
        cred[p] = FD;
      end else begin
        logic rdy_e, fire_e, pop, h;
        logic [AW-1:0] a;
        rdy_e  = (cred[p] != 0);
        fire_e = bus.req_valid_i[p] && rdy_e && !bus.flush_i;
        chk($sformatf("req_ready[%0d]", p), 64'(bus.req_ready_o[p]), 64'(rdy_e));
        chk($sformatf("cam_read[%0d]", p), 64'(bus.cam_read_o[p]), 64'(fire_e));
        if (fire_e) begin
          chk($sformatf("cam_read_data[%0d]", p), 64'(bus.cam_read_data_o[p*WIDTH +: WIDTH]),
              64'(bus.req_data_i[p*WIDTH +: WIDTH]));
          cam_lookup(bus.req_data_i[p*WIDTH +: WIDTH], h, a);
          sbq[p].push_back('{hit: h, addr: a, tag: bus.req_tag_i[p*TAG_W +: TAG_W], rdy: cyc + 2});
        end
        pop = bus.rsp_valid_o[p] && bus.rsp_ready_i[p];
        if (bus.flush_i) cred[p] = FD;
        else cred[p] = cred[p] - int'(fire_e) + int'(pop);
      end
    end
  end

  // Response monitor: pops the scoreboard whenever a response is consumed
  always @(negedge clk) begin
    for (int p = 0; p < READ; p++) begin
      if (rst) begin
        sbq[p].delete();
      end else begin
        logic exp_v;
        exp_v = (sbq[p].size() != 0) && (sbq[p][0].rdy <= cyc);
        chk($sformatf("rsp_valid[%0d]", p), 64'(bus.rsp_valid_o[p]), 64'(exp_v));
        if (bus.rsp_valid_o[p] && exp_v && bus.rsp_ready_i[p]) begin
          chk($sformatf("rsp_hit[%0d]", p), 64'(bus.rsp_hit_o[p]), 64'(sbq[p][0].hit));
          chk($sformatf("rsp_addr[%0d]", p), 64'(bus.rsp_addr_o[p*AW +: AW]), 64'(sbq[p][0].addr));
          chk($sformatf("rsp_tag[%0d]", p), 64'(bus.rsp_tag_o[p*TAG_W +: TAG_W]), 64'(sbq[p][0].tag));
          void'(sbq[p].pop_front());
        end
        if (bus.flush_i) sbq[p].delete();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic v, input logic [WIDTH-1:0] key, input logic [TAG_W-1:0] tag);
    bus.req_valid_i[p]               = v;
    bus.req_data_i[p*WIDTH +: WIDTH] = key;
    bus.req_tag_i[p*TAG_W +: TAG_W]  = tag;
  endtask

  task automatic idle_all();
    for (int p = 0; p < READ; p++) set_req(p, 1'b0, '0, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid_i = '0;
    bus.req_data_i  = '0;
    bus.req_tag_i   = '0;
    bus.flush_i     = 1'b0;
    bus.rsp_ready_i = '0;
    repeat (3) tick();
    chk("reset_req_ready", 64'(bus.req_ready_o), 64'(3'b111));
    chk("reset_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("reset_rsp_hit", 64'(bus.rsp_hit_o), 64'd0);
    chk("reset_rsp_addr", 64'(bus.rsp_addr_o), 64'd0);
    chk("reset_rsp_tag", 64'(bus.rsp_tag_o), 64'd0);
    chk("reset_cam_read", 64'(bus.cam_read_o), 64'd0);
    rst = 1'b0;
    tick();

    // single hit then miss
    bus.rsp_ready_i = '1;
    set_req(0, 1'b1, 50'd5, 4'd3);
    tick();
    idle_all();
    repeat (4) tick();
    set_req(1, 1'b1, 50'h3FF, 4'd7);
    tick();
    idle_all();
    repeat (4) tick();

    // backpressure on port 2: keys 1..6 with tags 0..5
    begin
      int idx = 0;
      bus.rsp_ready_i[2] = 1'b0;
      for (int c = 0; c < 30; c++) begin
        if (c == 10) bus.rsp_ready_i[2] = 1'b1;
        if (idx < 6) set_req(2, 1'b1, WIDTH'(idx + 1), TAG_W'(idx));
        else set_req(2, 1'b0, '0, '0);
        @(negedge clk);
        if (bus.req_valid_i[2] && bus.req_ready_o[2]) idx++;
        tick();
      end
      chk("bp_all_fired", 64'(idx), 64'd6);
    end

    // credit edge on port 0: three buffered, then fire and pop together at credit 1
    bus.rsp_ready_i[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(0, 1'b1, WIDTH'(i + 10), TAG_W'(i));
      tick();
    end
    idle_all();
    repeat (3) tick();
    set_req(0, 1'b1, 50'd7, 4'd9);
    bus.rsp_ready_i[0] = 1'b1;
    tick();
    idle_all();
    @(negedge clk);
    chk("credit_edge_ready", 64'(bus.req_ready_o[0]), 64'd1);
    repeat (6) tick();

    // flush with port 0 busy
    bus.rsp_ready_i[0] = 1'b0;
    set_req(0, 1'b1, 50'd3, 4'd1);
    tick();
    idle_all();
    tick();
    set_req(0, 1'b1, 50'd20, 4'd2);
    tick();
    set_req(0, 1'b1, 50'd21, 4'd4);
    tick();
    idle_all();
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    @(negedge clk);
    chk("flush_rsp_valid", 64'(bus.rsp_valid_o[0]), 64'd0);
    chk("flush_req_ready", 64'(bus.req_ready_o[0]), 64'd1);
    repeat (3) tick();
    chk("flush_late_ignored", 64'(bus.rsp_valid_o[0]), 64'd0);
    bus.rsp_ready_i[0] = 1'b1;
    set_req(0, 1'b1, 50'd2, 4'd6);
    tick();
    idle_all();
    repeat (4) tick();

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      for (int p = 0; p < READ; p++) begin
        logic [WIDTH-1:0] key;
        key = ($urandom_range(0, 3) == 0) ? WIDTH'({$urandom(), $urandom()}) : WIDTH'($urandom_range(0, 20));
        set_req(p, $urandom_range(0, 99) < 60, key, TAG_W'($urandom_range(0, 15)));
        bus.rsp_ready_i[p] = ($urandom_range(0, 99) < 65);
      end
      bus.flush_i = ($urandom_range(0, 199) == 0);
      tick();
    end
    idle_all();
    bus.flush_i     = 1'b0;
    bus.rsp_ready_i = '1;
    repeat (10) tick();
    @(negedge clk);
    for (int p = 0; p < READ; p++) chk($sformatf("drain_empty[%0d]", p), 64'(sbq[p].size()), 64'd0);
    tick();

    // reset in the middle of activity on every port
    for (int c = 0; c < 6; c++) begin
      for (int p = 0; p < READ; p++) begin
        set_req(p, 1'b1, WIDTH'($urandom_range(1, 16)), TAG_W'($urandom_range(0, 15)));
        bus.rsp_ready_i[p] = (c > 3);
      end
      tick();
    end
    rst = 1'b1;
    #1;
    chk("midrst_req_ready", 64'(bus.req_ready_o), 64'(3'b111));
    chk("midrst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("midrst_cam_read", 64'(bus.cam_read_o), 64'd0);
    chk("midrst_rsp_addr", 64'(bus.rsp_addr_o), 64'd0);
    chk("midrst_rsp_tag", 64'(bus.rsp_tag_o), 64'd0);
    idle_all();
    repeat (2) tick();
    rst = 1'b0;
    bus.rsp_ready_i = '1;
    tick();
    set_req(0, 1'b1, 50'd16, 4'd5);
    tick();
    idle_all();
    @(negedge clk);
    chk("post_rst_pending", 64'(sbq[0].size()), 64'd1);
    repeat (4) tick();
    @(negedge clk);
    chk("post_rst_done", 64'(sbq[0].size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
